// File: rtl/comm_pkg.sv
// Shared opcodes, frame FSM state type and checksum helper for the copter command framer.
// The checksum helper is only referenced when FRAME_CHKSUM_EN is defined.
package comm_pkg;

    localparam logic [7:0] REQ_BATT  = 8'h01;
    localparam logic [7:0] SET_PTCH  = 8'h02;
    localparam logic [7:0] SET_ROLL  = 8'h03;
    localparam logic [7:0] SET_YAW   = 8'h04;
    localparam logic [7:0] SET_THRST = 8'h05;
    localparam logic [7:0] CALIBRATE = 8'h06;
    localparam logic [7:0] EMER_LAND = 8'h07;
    localparam logic [7:0] MTRS_OFF  = 8'h08;

    typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2, CHK = 2'd3} frm_state_t;

    // A frame is good when all four bytes sum to 8'hFF modulo 256.
    function automatic logic chk_ok(input logic [7:0] op, input logic [7:0] hi,
                                    input logic [7:0] lo, input logic [7:0] ck);
        logic [7:0] s;
        s = op + hi + lo + ck;
        return s == 8'hFF;
    endfunction

endpackage

// File: rtl/cmd_frame_asm_if.sv
// Byte-in / frame-out bus between the UART receiver, the framer and the command consumer.
interface cmd_frame_asm_if;
    // Handshakes: a byte is transferred in every cycle where rx_rdy=1 and clr_rx_rdy=1;
    // the receiver holds rx_data stable while rx_rdy=1 and drops rx_rdy the clk after clr_rx_rdy.
    // A frame is offered while cmd_rdy=1; the consumer acknowledges with a 1-clk clr_cmd_rdy.
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic        cmd_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        clr_cmd_rdy;
    logic        frm_err;

    modport master (
        output rx_rdy, rx_data, clr_cmd_rdy,
        input  clr_rx_rdy, cmd_rdy, cmd, data, frm_err
    );

    modport slave (
        input  rx_rdy, rx_data, clr_cmd_rdy,
        output clr_rx_rdy, cmd_rdy, cmd, data, frm_err
    );
endinterface

// File: rtl/frame_timer.sv
// Saturating inter-byte timer: counts clks since the last accepted byte, flags the last legal clk.
module frame_timer #(
    parameter int  TIMEOUT_CLKS = 100000,
    localparam int TMR_W        = $clog2(TIMEOUT_CLKS + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    logic [TMR_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != TMR_W'(TIMEOUT_CLKS))) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (r_cnt == TMR_W'(TIMEOUT_CLKS - 1));

endmodule

// File: rtl/cmd_frame_asm.sv
// Assembles opcode/data_hi/data_lo bytes from the UART into a double-buffered command frame.
// Define FRAME_CHKSUM_EN to require a fourth checksum byte per frame.
module cmd_frame_asm
    import comm_pkg::*;
#(
    parameter int TIMEOUT_CLKS = 100000
) (
    input  logic             clk,
    input  logic             rst_n,
    cmd_frame_asm_if.slave   bus,
    output frm_state_t       o_dbg_state
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_HIGH = HIGH;
    localparam logic [1:0] S_LOW  = LOW;
`ifdef FRAME_CHKSUM_EN
    localparam logic [1:0] S_CHK  = CHK;
`endif

    logic [1:0]  r_state;
    logic [7:0]  r_op;
    logic [7:0]  r_hi;
    logic [7:0]  r_cmd;
    logic [15:0] r_data;
    logic        r_cmd_rdy;
    logic        r_frm_err;
`ifdef FRAME_CHKSUM_EN
    logic [7:0]  r_lo;
    logic        w_chk_ok;
`endif

    logic w_accept;
    logic w_expired;
    logic w_timeout;
    logic w_tmr_clr;

    // Every state takes a byte as soon as it is offered; only reset blocks acceptance.
    assign w_accept  = bus.rx_rdy & rst_n;
    assign w_tmr_clr = w_accept | (r_state == S_IDLE);
    assign w_timeout = (r_state != S_IDLE) & w_expired & ~w_accept;

`ifdef FRAME_CHKSUM_EN
    assign w_chk_ok = chk_ok(r_op, r_hi, r_lo, bus.rx_data);
`endif

    frame_timer #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_tmr_clr),
        .i_en      (1'b1),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_op      <= '0;
            r_hi      <= '0;
            r_cmd     <= '0;
            r_data    <= '0;
            r_cmd_rdy <= 1'b0;
            r_frm_err <= 1'b0;
`ifdef FRAME_CHKSUM_EN
            r_lo      <= '0;
`endif
        end else begin
            r_frm_err <= 1'b0;
            // Lowest-priority cmd_rdy source first; later assignments override it.
            if (bus.clr_cmd_rdy) r_cmd_rdy <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op      <= bus.rx_data;
                        r_cmd_rdy <= 1'b0;
                        r_state   <= S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (w_accept) begin
                        r_hi    <= bus.rx_data;
                        r_state <= S_LOW;
                    end else if (w_timeout) begin
                        r_frm_err <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                S_LOW: begin
                    if (w_accept) begin
`ifdef FRAME_CHKSUM_EN
                        r_lo    <= bus.rx_data;
                        r_state <= S_CHK;
`else
                        r_cmd     <= r_op;
                        r_data    <= {r_hi, bus.rx_data};
                        r_cmd_rdy <= 1'b1;
                        r_state   <= S_IDLE;
`endif
                    end else if (w_timeout) begin
                        r_frm_err <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
`ifdef FRAME_CHKSUM_EN
                S_CHK: begin
                    if (w_accept) begin
                        if (w_chk_ok) begin
                            r_cmd     <= r_op;
                            r_data    <= {r_hi, r_lo};
                            r_cmd_rdy <= 1'b1;
                        end else begin
                            r_frm_err <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end else if (w_timeout) begin
                        r_frm_err <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.clr_rx_rdy = w_accept;
    assign bus.cmd_rdy    = r_cmd_rdy;
    assign bus.cmd        = r_cmd;
    assign bus.data       = r_data;
    assign bus.frm_err    = r_frm_err;
    assign o_dbg_state    = frm_state_t'(r_state);

endmodule

// File: tb/tb_cmd_frame_asm.sv
// Directed bench for cmd_frame_asm with a UART byte model and a frame scoreboard.
module tb_cmd_frame_asm;
    import comm_pkg::*;

    localparam int TMO = 64;
`ifdef FRAME_CHKSUM_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif

    logic clk;
    logic rst_n;
    frm_state_t dbg_state;
    cmd_frame_asm_if bus();

    cmd_frame_asm #(.TIMEOUT_CLKS(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int clr_cnt  = 0;
    int err_cnt  = 0;
    logic prev_rdy = 1'b0;
    logic [23:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_checks++;
        assert (obs === req) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, req);
    endtask

    function automatic logic [7:0] csum(input logic [7:0] op, input logic [7:0] hi,
                                        input logic [7:0] lo);
        logic [7:0] s;
        s = op + hi + lo;
        return 8'hFF - s;
    endfunction

    // monitors: sampled on the falling edge, inputs change just after the rising edge
    always @(negedge clk) begin
        if (bus.clr_rx_rdy) clr_cnt++;
        if (bus.frm_err) err_cnt++;
        if (rst_n && bus.cmd_rdy && !prev_rdy) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_frame", 32'(exp_q.size()), 32'd1);
            end else begin
                chk("sb_frame", {8'h00, bus.cmd, bus.data}, {8'h00, exp_q.pop_front()});
            end
        end
        prev_rdy = bus.cmd_rdy;
    end

    // driver tasks: all entered and left at posedge+1
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic got;
        got = 1'b0;
        bus.rx_rdy  = 1'b1;
        bus.rx_data = b;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.clr_rx_rdy) got = 1'b1;
            @(posedge clk);
            #1;
            if (got) break;
        end
        bus.rx_rdy = 1'b0;
        if (!got) chk("byte_not_accepted", 32'(got), 32'd1);
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [7:0] hi, input logic [7:0] lo,
                              input logic clr_last);
        send_byte(op);
        send_byte(hi);
`ifdef FRAME_CHKSUM_EN
        send_byte(lo);
        bus.clr_cmd_rdy = clr_last;
        send_byte(csum(op, hi, lo));
`else
        bus.clr_cmd_rdy = clr_last;
        send_byte(lo);
`endif
        bus.clr_cmd_rdy = 1'b0;
    endtask

    int c0;
    int e0;
    int cyc;

    initial begin
        rst_n           = 1'b0;
        bus.rx_rdy      = 1'b0;
        bus.rx_data     = 8'h00;
        bus.clr_cmd_rdy = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // power-on reset state
        @(negedge clk);
        chk("rst_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
        chk("rst_cmd", 32'(bus.cmd), 32'h00);
        chk("rst_data", 32'(bus.data), 32'h0000);
        chk("rst_frm_err", 32'(bus.frm_err), 32'd0);
        chk("rst_clr_rx_rdy", 32'(bus.clr_rx_rdy), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        @(posedge clk);
        #1;

        // basic frame, one clr_rx_rdy per byte
        c0 = clr_cnt;
        exp_q.push_back({8'h05, 16'h0123});
        send_byte(8'h05);
        send_byte(8'h01);
`ifdef FRAME_CHKSUM_EN
        send_byte(8'h23);
`endif
        chk("pre_final_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
`ifdef FRAME_CHKSUM_EN
        send_byte(csum(8'h05, 8'h01, 8'h23));
`else
        send_byte(8'h23);
`endif
        @(negedge clk);
        chk("clr_pulses", 32'(clr_cnt - c0), 32'(NB));
        chk("t2_cmd_rdy", 32'(bus.cmd_rdy), 32'd1);
        chk("t2_cmd", 32'(bus.cmd), 32'h05);
        chk("t2_data", 32'(bus.data), 32'h0123);
        @(posedge clk);
        #1;
        bus.clr_cmd_rdy = 1'b1;
        idle(1);
        bus.clr_cmd_rdy = 1'b0;
        chk("ack_clears", 32'(bus.cmd_rdy), 32'd0);

        // partial frame times out after exactly TMO clks
        e0 = err_cnt;
        cyc = 0;
        send_byte(8'h02);
        send_byte(8'h40);
        for (int i = 1; i <= 2 * TMO; i++) begin
            @(posedge clk);
            #1;
            if (bus.frm_err) begin
                cyc = i;
                break;
            end
        end
        chk("timeout_clks", 32'(cyc), 32'(TMO));
        idle(4);
        chk("timeout_one_pulse", 32'(err_cnt - e0), 32'd1);
        chk("timeout_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
        chk("timeout_cmd_kept", 32'(bus.cmd), 32'h05);
        chk("timeout_data_kept", 32'(bus.data), 32'h0123);
        chk("timeout_state", 32'(dbg_state), 32'(IDLE));
        exp_q.push_back({8'h03, 16'h0010});
        send_frame(8'h03, 8'h00, 8'h10, 1'b0);
        chk("recover_cmd", 32'(bus.cmd), 32'h03);
        chk("recover_data", 32'(bus.data), 32'h0010);

        // new first byte clears cmd_rdy but keeps the committed frame
        exp_q.push_back({8'h01, 16'hABCD});
        send_frame(8'h01, 8'hAB, 8'hCD, 1'b0);
        chk("t4_cmd_rdy_set", 32'(bus.cmd_rdy), 32'd1);
        send_byte(8'h08);
        @(negedge clk);
        chk("t4_start_clears", 32'(bus.cmd_rdy), 32'd0);
        chk("t4_cmd_stable", 32'(bus.cmd), 32'h01);
        chk("t4_data_stable", 32'(bus.data), 32'hABCD);
        @(posedge clk);
        #1;
        exp_q.push_back({8'h08, 16'h0000});
        send_byte(8'h00);
`ifdef FRAME_CHKSUM_EN
        send_byte(8'h00);
        send_byte(csum(8'h08, 8'h00, 8'h00));
`else
        send_byte(8'h00);
`endif
        chk("t4_cmd", 32'(bus.cmd), 32'h08);
        chk("t4_cmd_rdy", 32'(bus.cmd_rdy), 32'd1);

        // completion beats a simultaneous acknowledge
        exp_q.push_back({8'h04, 16'h1234});
        send_frame(8'h04, 8'h12, 8'h34, 1'b1);
        @(negedge clk);
        chk("complete_vs_ack", 32'(bus.cmd_rdy), 32'd1);
        @(posedge clk);
        #1;

        // byte arriving in the last legal clk is accepted without error
        e0 = err_cnt;
        exp_q.push_back({8'h07, 16'h0055});
        send_byte(8'h07);
        idle(TMO - 1);
        send_byte(8'h00);
        idle(TMO - 1);
        send_byte(8'h55);
`ifdef FRAME_CHKSUM_EN
        idle(TMO - 1);
        send_byte(csum(8'h07, 8'h00, 8'h55));
`endif
        idle(2);
        chk("edge_no_err", 32'(err_cnt - e0), 32'd0);
        chk("edge_cmd", 32'(bus.cmd), 32'h07);
        chk("edge_data", 32'(bus.data), 32'h0055);

`ifdef FRAME_CHKSUM_EN
        // checksum pass then fail
        e0 = err_cnt;
        exp_q.push_back({8'h06, 16'h0000});
        send_byte(8'h06);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'hF9);
        chk("chk_pass_rdy", 32'(bus.cmd_rdy), 32'd1);
        chk("chk_pass_cmd", 32'(bus.cmd), 32'h06);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'hF8);
        idle(2);
        chk("chk_fail_err", 32'(err_cnt - e0), 32'd1);
        chk("chk_fail_cmd", 32'(bus.cmd), 32'h06);
        chk("chk_fail_data", 32'(bus.data), 32'h0000);
        chk("chk_fail_rdy", 32'(bus.cmd_rdy), 32'd0);
`endif

        // reset in the middle of a frame while a frame is pending
        exp_q.push_back({8'h05, 16'h0707});
        send_frame(8'h05, 8'h07, 8'h07, 1'b0);
        e0 = err_cnt;
        send_byte(8'h02);
        send_byte(8'h09);
        rst_n = 1'b0;
        bus.rx_rdy  = 1'b1;
        bus.rx_data = 8'h33;
        @(negedge clk);
        chk("midrst_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
        chk("midrst_cmd", 32'(bus.cmd), 32'h00);
        chk("midrst_data", 32'(bus.data), 32'h0000);
        chk("midrst_frm_err", 32'(bus.frm_err), 32'd0);
        chk("midrst_clr_rx_rdy", 32'(bus.clr_rx_rdy), 32'd0);
        @(posedge clk);
        #1;
        bus.rx_rdy = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(2 * TMO);
        chk("midrst_no_err", 32'(err_cnt - e0), 32'd0);
        chk("midrst_state", 32'(dbg_state), 32'(IDLE));
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // watchdog
    initial begin
        #2000000;
        chk("watchdog", 32'd1, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
